gb_read_streamer: RTL
=====================

Name: gb_read_streamer

Overview:
- Read-side client of the global buffer.
- Accepts a burst command (start address, beat count) and issues one global-buffer read address per cycle on a single read port.
- Tracks the buffer's fixed read latency with a tag pipeline, captures the returned data into a local FIFO, and presents it as a valid/ready stream.
- Sits between the global buffer's raddr/dout port and the PE-array loaders (input/weight/output fetch).

Parameters:
- ADDR_WIDTH, 17, global-buffer word address width (bit16 = output bank, bit15 = weight/input select).
- DATA_WIDTH, 128, word width.
- LEN_WIDTH, 16, burst length field width.
- RD_LATENCY, 3, cycles from raddr presented to data valid on gb_dout.
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥ RD_LATENCY+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  number of words to read (0 allowed)
- gb_raddr  out  ADDR_WIDTH  read address to global buffer
- gb_dout  in  DATA_WIDTH  read data from global buffer
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  DATA_WIDTH  stream data
- m_last  out  1  marks final word of burst
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when burst completes

Behaviour:
- Reset (async, rst=1) clears everything:
  - state=IDLE, cmd_ready=1, gb_raddr=0, m_valid=0, m_last=0, busy=0, done=0.
  - FIFO is emptied, the tag pipeline is cleared, counters are 0.
  - Reset mid-burst discards all in-flight and buffered data; no done pulse is produced.
- State machine: IDLE, ISSUE, DRAIN.
  - IDLE: cmd_valid & cmd_ready latches addr_q=cmd_addr and rem_q=cmd_len.
    - cmd_len≠0 → ISSUE.
    - cmd_len=0 → done pulses the next cycle and state stays IDLE; no reads are issued.
  - ISSUE: a read is issued in a cycle when credit = (fifo_count + inflight_count) < FIFO_DEPTH.
    - gb_raddr is driven from addr_q combinationally.
    - On each issue: addr_q ← addr_q+1, modulo 2^ADDR_WIDTH (wraps 0x1FFFF → 0x00000), and rem_q decrements.
    - The issue that makes rem_q reach 0 → DRAIN.
  - DRAIN: waits until the tag pipeline and FIFO are empty and the last beat has handshaked → IDLE. done pulses in the same cycle as the m_last handshake.
- gb_raddr holds its last value when not issuing. The buffer has no read enable, so reads outside an issue are untagged and their data is ignored.
- Tag pipeline:
  - RD_LATENCY stages, each holding {valid, last}.
  - An issue in cycle t makes the tag valid at the pipe output in cycle t+RD_LATENCY.
  - gb_dout is pushed into the FIFO in that cycle, along with the last flag.
  - inflight_count = popcount of valid tags.
- Credit is conservative: a same-cycle FIFO pop does not add credit. This guarantees a push never meets a full FIFO. Overflow is impossible by construction; the bench asserts it.
- FIFO behaviour:
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Push into an empty FIFO makes m_valid=1 in the next cycle; there is no fall-through.
  - m_data and m_last come from the head entry.
  - Pop occurs when m_valid & m_ready.
- Stream rule: m_data and m_last are stable while m_valid=1 and m_ready=0.
- Throughput: with m_ready held at 1, one word per cycle is sustained after the initial latency.
- First-word latency: cmd handshake at cycle 0; first issue at cycle 1; data in the FIFO at the end of cycle 1+RD_LATENCY; m_valid=1 at cycle 2+RD_LATENCY (5 with defaults).
- Exactly cmd_len words are delivered, in address order. m_last=1 only on the final word.
- cmd_valid while busy is ignored: cmd_ready=0 and the command is not latched.

Test Plan:
- Basic burst: cmd_addr=0x00010, cmd_len=4, m_ready=1, buffer model returns data=address → m_valid first high at cycle 5; data 0x10,0x11,0x12,0x13 on consecutive cycles; m_last on 0x13; done pulse on that same cycle; busy falls the next cycle.
- Backpressure: cmd_len=20, m_ready=0 for 30 cycles → exactly 8 issues and then gb_raddr stalls; FIFO holds 8 with no loss. Release m_ready → all 20 words arrive in order with no duplicates.
- Toggling ready: m_ready pattern 1,0,1,1,0 repeating, cmd_len=16 → 16 words in order; m_data stable across every stall cycle.
- Wrap and bank crossing: cmd_addr=0x1FFFE, cmd_len=4 → raddr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; data matches the model.
- Zero length: cmd_len=0 → no issue cycles; done=1 exactly one cycle after the handshake; m_valid stays 0.
- Reset mid-burst: assert rst asynchronously (between clock edges) during a cmd_len=10 burst after 3 words are delivered → outputs reset immediately, no done pulse. A new burst with cmd_addr=0x08000, cmd_len=2 returns only 0x08000 and 0x08001.

Source files
------------

// File: rtl/gb_read_streamer_if.sv
// Bundle of signals between the global-buffer read streamer, its command
// source, the global-buffer read port and the downstream stream consumer.
interface gb_read_streamer_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [ADDR_WIDTH-1:0] gb_raddr;
    logic [DATA_WIDTH-1:0] gb_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    // Streamer side.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, gb_dout, m_ready,
        output cmd_ready, gb_raddr, m_valid, m_data, m_last, busy, done
    );

    // Environment side: command source, global buffer and stream consumer.
    modport master (
        output cmd_valid, cmd_addr, cmd_len, gb_dout, m_ready,
        input  cmd_ready, gb_raddr, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/gb_read_streamer.sv
// Global-buffer read streamer: turns a (start address, length) burst command
// into one read address per cycle, follows the buffer's fixed read latency
// with a tag pipeline and buffers returned words in a FIFO presented as a
// valid/ready stream. Issue is credit-limited so the FIFO can never overflow.
module gb_read_streamer #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    gb_read_streamer_if.slave gb_io
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  zero_done_q, zero_done_d;

    logic [RD_LATENCY-1:0] tag_vld_q, tag_last_q;
    logic [INF_W-1:0]      inflight_cnt;

    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic [DATA_WIDTH:0]   head;

    logic credit_ok, issue, push, pop, drain_done;

    // Count reads still travelling through the buffer's latency.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + INF_W'(tag_vld_q[i]);
        end
    end

    // A same-cycle pop is deliberately not counted as credit, so every word
    // in flight always has a free FIFO slot waiting for it.
    assign credit_ok  = (int'(fifo_cnt_q) + int'(inflight_cnt)) < FIFO_DEPTH;
    assign issue      = (state_q == S_ISSUE) && credit_ok;
    assign push       = tag_vld_q[RD_LATENCY-1];
    assign head       = fifo_mem[rd_ptr_q];
    assign pop        = gb_io.m_valid && gb_io.m_ready;
    assign drain_done = (state_q == S_DRAIN) && pop && gb_io.m_last &&
                        (fifo_cnt_q == CNT_W'(1)) && (tag_vld_q == '0);

    // Next-state and burst bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        zero_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gb_io.cmd_valid) begin
                    addr_d = gb_io.cmd_addr;
                    rem_d  = gb_io.cmd_len;
                    if (gb_io.cmd_len != '0) state_d = S_ISSUE;
                    else                     zero_done_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, address, remaining count and zero-length done flag registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Tag pipeline: one {valid, last} stage per cycle of read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_last_q[0] <= issue && (rem_q == LEN_WIDTH'(1));
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    // FIFO storage write port.
    // NOTE: the data array is not reset; occupancy is tracked by the reset
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {tag_last_q[RD_LATENCY-1], gb_io.gb_dout};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign gb_io.cmd_ready = (state_q == S_IDLE);
    assign gb_io.busy      = (state_q != S_IDLE);
    assign gb_io.gb_raddr  = addr_q;
    assign gb_io.m_valid   = (fifo_cnt_q != '0);
    assign gb_io.m_data    = head[DATA_WIDTH-1:0];
    assign gb_io.m_last    = head[DATA_WIDTH] && gb_io.m_valid;
    assign gb_io.done      = zero_done_q || drain_done;
endmodule
